// File: rtl/serial_nibble_collector.sv
// serial_nibble_collector: packs converter bits D (LSB first) into nibbles,
// ORs the B flag per nibble, and queues {flag, nibble} in a show-ahead FIFO.
module serial_nibble_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     EN,
  input  logic                     SYNC,
  input  logic                     D,
  input  logic                     B,
  input  logic                     OUT_READY,
  output logic                     OUT_VALID,
  output logic [3:0]               OUT_DATA,
  output logic                     OUT_FLAG,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF,
  output logic [CNT_W-1:0]         FLAG_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]    phase;
  logic [2:0]    bits;
  logic          flag_acc;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;

  logic          restart;
  logic          step;
  logic          push;
  logic          push_flag;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;

  // Decode this cycle's collector action and the FIFO handshake.
  always_comb begin
    restart   = EN & SYNC;
    push      = EN & ~SYNC & (phase == 2'd3);
    step      = EN & ~SYNC & (phase != 2'd3);
    push_flag = B | flag_acc;
    full      = (count == LW'(DEPTH));
    pop       = OUT_VALID & OUT_READY;
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
  end

  // Show-ahead head; zero whenever the FIFO is empty.
  always_comb begin
    OUT_VALID = (count != '0);
    OUT_DATA  = '0;
    OUT_FLAG  = 1'b0;
    if (OUT_VALID) begin
      OUT_DATA = mem[rd_ptr][3:0];
      OUT_FLAG = mem[rd_ptr][4];
    end
    LEVEL = count;
  end

  // Serial collector: phase, partial nibble and running flag.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      phase    <= 2'd0;
      bits     <= 3'd0;
      flag_acc <= 1'b0;
    end else begin
      unique case (1'b1)
        restart: begin
          bits     <= {2'b00, D};
          flag_acc <= B;
          phase    <= 2'd1;
        end
        push: begin
          bits     <= 3'd0;
          flag_acc <= 1'b0;
          phase    <= 2'd0;
        end
        step: begin
          bits[phase] <= D;
          flag_acc    <= flag_acc | B;
          phase       <= phase + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Storage array; only written on an accepted push.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[wr_ptr] <= {push_flag, D, bits};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: ;
      endcase
    end
  end

  // Sticky overflow and saturating flagged-word count.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      OVF      <= 1'b0;
      FLAG_CNT <= '0;
    end else begin
      if (drop) OVF <= 1'b1;
      if (accept && push_flag && (FLAG_CNT != '1))
        FLAG_CNT <= FLAG_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_nibble_collector.sv
// tb_serial_nibble_collector: directed and random stimulus against
// a queue-based reference model, checked by an independent monitor.
module tb_serial_nibble_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       EN;
  logic       SYNC;
  logic       D;
  logic       B;
  logic       OUT_READY;
  logic       OUT_VALID;
  logic [3:0] OUT_DATA;
  logic       OUT_FLAG;
  logic [2:0] LEVEL;
  logic       OVF;
  logic [7:0] FLAG_CNT;

  serial_nibble_collector #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .EN(EN),
    .SYNC(SYNC),
    .D(D),
    .B(B),
    .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA),
    .OUT_FLAG(OUT_FLAG),
    .LEVEL(LEVEL),
    .OVF(OVF),
    .FLAG_CNT(FLAG_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] data;
    logic       flag;
  } ent_t;

  ent_t       exp_q[$];
  logic [1:0] cur[$];
  logic       m_ovf;
  int         m_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_on = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d",
               nm, $time, act, req);
    end
  endtask

  // Monitor: compare visible outputs to the model before each edge.
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("valid", 32'(OUT_VALID), 32'(exp_q.size() != 0));
      chk("level", 32'(LEVEL), 32'(exp_q.size()));
      chk("ovf", 32'(OVF), 32'(m_ovf));
      chk("flag_cnt", 32'(FLAG_CNT), 32'(m_cnt));
      if (exp_q.size() != 0) begin
        chk("data", 32'(OUT_DATA), 32'(exp_q[0].data));
        chk("flag", 32'(OUT_FLAG), 32'(exp_q[0].flag));
        if (OUT_READY && !CLR) void'(exp_q.pop_front());
      end else begin
        chk("data_idle", 32'(OUT_DATA), 32'd0);
        chk("flag_idle", 32'(OUT_FLAG), 32'd0);
      end
    end
  end

  task automatic model_clear();
    exp_q.delete();
    cur.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // One clock of stimulus; the model forms nibbles from a bit list.
  task automatic step(input logic en, input logic sy,
                      input logic d, input logic b,
                      input logic rdy);
    bit   done;
    ent_t w;
    done = 0;
    EN = en;
    SYNC = sy;
    D = d;
    B = b;
    OUT_READY = rdy;
    if (en) begin
      if (sy) cur.delete();
      cur.push_back({d, b});
      if (cur.size() == 4) begin
        done = 1;
        w.data = '0;
        w.flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
          w.data[i] = cur[i][1];
          w.flag = w.flag | cur[i][0];
        end
        cur.delete();
      end
    end
    @(posedge CLK);
    #1;
    if (done) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(w);
        if (w.flag && m_cnt < CMAX) m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic do_clr();
    EN = 0;
    SYNC = 0;
    OUT_READY = 0;
    CLR = 1;
    model_clear();
    @(posedge CLK);
    #1;
    CLR = 0;
  endtask

  task automatic word(input logic [3:0] w, input logic [3:0] bv,
                      input logic sy, input logic rdy);
    for (int i = 0; i < 4; i++)
      step(1'b1, sy && (i == 0), w[i], bv[i], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    CLR = 1;
    EN = 0;
    SYNC = 0;
    D = 0;
    B = 0;
    OUT_READY = 0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    mon_on = 1;
    @(posedge CLK);
    #1;
    CLR = 0;

    // Reset mid-word, then a clean nibble.
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    do_clr();
    word(4'b1001, 4'b0000, 0, 0);
    idle(3, 1);

    // Sync on bit0, 1,0,1,1 -> 1101.
    word(4'b1101, 4'b0000, 1, 0);
    idle(2, 0);
    idle(2, 1);

    // Flag on the 4th bit, consumer ready.
    word(4'b1100, 4'b1000, 0, 1);
    idle(2, 1);

    // Five words into a stalled FIFO; fifth dropped.
    for (int k = 0; k < 5; k++)
      word(4'($urandom), 4'($urandom), 0, 0);
    idle(6, 1);

    // Sync after two bits discards the partial word.
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    word(4'b1111, 4'b0000, 1, 0);
    idle(3, 1);

    // Full FIFO, gapped EN, pop coincides with the push.
    do_clr();
    for (int k = 0; k < 4; k++)
      word(4'($urandom), 4'b0000, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    idle(6, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_clr();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           1'($urandom), 1'($urandom),
           1'($urandom));
    end
    idle(6, 1);

    // Drive FLAG_CNT into saturation.
    do_clr();
    for (int k = 0; k < CMAX + 20; k++)
      word(4'($urandom), 4'b0001, 0, 1);
    idle(4, 1);

    mon_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
